// File: rtl/lanzones_pkg.sv
// ============================================================================
// Module      : lanzones_pkg
// Description : Shared stage indices, FSM state encoding and constants for the
//               lanzones pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lanzones_pkg;

  localparam int STG_FI = 0;
  localparam int STG_DI = 1;
  localparam int STG_EX = 2;
  localparam int STG_MA = 3;
  localparam int STG_WB = 4;
  localparam int NSTG   = 5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    MCWAIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lanzones_pipe_ctrl_if.sv
// ============================================================================
// Module      : lanzones_pipe_ctrl_if
// Description : Fetch handshake, hazard inputs and stage-control outputs of the
//               lanzones pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lanzones_pipe_ctrl_if #(
  parameter int XLEN = 32
);

  logic            fi_vld;
  logic            fi_rdy;
  logic [XLEN-1:0] fi_addr;
  logic [4:0]      di_rs1;
  logic [4:0]      di_rs2;
  logic            di_use_rs1;
  logic            di_use_rs2;
  logic [4:0]      ex_rd;
  logic            ex_wen;
  logic            ex_is_load;
  logic            ex_mc;
  logic            ex_br_taken;
  logic [XLEN-1:0] ex_br_tgt;
  logic            ma_stall;
  logic [4:0]      stg_en;
  logic [4:0]      stg_vld;
  logic [31:0]     stall_cnt;

  // Controller side
  modport master (
    input  fi_vld, di_rs1, di_rs2, di_use_rs1, di_use_rs2,
           ex_rd, ex_wen, ex_is_load, ex_mc, ex_br_taken, ex_br_tgt, ma_stall,
    output fi_rdy, fi_addr, stg_en, stg_vld, stall_cnt
  );

  // Datapath / instruction-memory side
  modport slave (
    output fi_vld, di_rs1, di_rs2, di_use_rs1, di_use_rs2,
           ex_rd, ex_wen, ex_is_load, ex_mc, ex_br_taken, ex_br_tgt, ma_stall,
    input  fi_rdy, fi_addr, stg_en, stg_vld, stall_cnt
  );

endinterface

`default_nettype wire

// File: rtl/lanzones_hazard_det.sv
// ============================================================================
// Module      : lanzones_hazard_det
// Description : Load-use hazard compare between the DI and EX instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lanzones_hazard_det (
  input  logic       di_vld,
  input  logic       ex_vld,
  input  logic [4:0] di_rs1,
  input  logic [4:0] di_rs2,
  input  logic       di_use_rs1,
  input  logic       di_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_wen,
  input  logic       ex_is_load,
  output logic       lu_hit
);

  logic w_src_match;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_src_match = (di_use_rs1 && (di_rs1 == ex_rd)) ||
                       (di_use_rs2 && (di_rs2 == ex_rd));

  assign lu_hit = di_vld && ex_vld && ex_is_load && ex_wen &&
                  (ex_rd != 5'd0) && w_src_match;

endmodule

`default_nettype wire

// File: rtl/lanzones_pipe_ctrl.sv
// ============================================================================
// Module      : lanzones_pipe_ctrl
// Description : Five-stage pipeline sequencer: PC, fetch handshake, per-stage
//               load enables/valids, stall and branch-flush resolution.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lanzones_pipe_ctrl
  import lanzones_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              EX_MC_CYC = 4,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
  input  logic                clk,
  input  logic                rstn,
  lanzones_pipe_ctrl_if.master bus
);

  localparam int              c_MC_W    = (EX_MC_CYC > 2) ? $clog2(EX_MC_CYC - 1) : 1;
  localparam logic [c_MC_W-1:0] c_MC_LOAD = c_MC_W'(EX_MC_CYC - 2);

  state_t            r_state, w_state_nxt;
  logic [c_MC_W-1:0] r_mc_cnt, w_mc_cnt_nxt;
  logic [XLEN-1:0]   r_pc, w_pc_nxt;
  logic [NSTG-1:0]   r_vld, w_vld_nxt;
  logic [31:0]       r_stall_cnt;
  logic [NSTG-1:0]   w_en;
  logic              w_fi_rdy;
  logic              w_branch;
  logic              w_lu_hit;
  logic              w_mc_hold;
  logic              w_lu_stall;
  logic              w_fetch;

  lanzones_hazard_det u_hazard (
    .di_vld     (r_vld[STG_DI]),
    .ex_vld     (r_vld[STG_EX]),
    .di_rs1     (bus.di_rs1),
    .di_rs2     (bus.di_rs2),
    .di_use_rs1 (bus.di_use_rs1),
    .di_use_rs2 (bus.di_use_rs2),
    .ex_rd      (bus.ex_rd),
    .ex_wen     (bus.ex_wen),
    .ex_is_load (bus.ex_is_load),
    .lu_hit     (w_lu_hit)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= BOOT;
      r_mc_cnt    <= '0;
      r_pc        <= BOOT_ADDR;
      r_vld       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
      r_pc     <= w_pc_nxt;
      r_vld    <= w_vld_nxt;
      if ((r_state != BOOT) && !w_en[STG_FI] && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    w_pc_nxt     = r_pc;
    w_vld_nxt    = r_vld;
    w_en         = '0;
    w_fi_rdy     = 1'b0;
    w_branch     = 1'b0;
    w_mc_hold    = 1'b0;
    w_lu_stall   = 1'b0;
    w_fetch      = 1'b0;

    case (r_state)
      BOOT: w_state_nxt = RUN;

      RUN, MCWAIT: begin
        // MCWAIT with a zero count is the release cycle: EX advances normally
        w_mc_hold = ((r_state == RUN) && r_vld[STG_EX] && bus.ex_mc) ||
                    ((r_state == MCWAIT) && (r_mc_cnt != '0));

        if (bus.ma_stall) begin
          w_en              = 5'b10000;
          w_vld_nxt[STG_WB] = 1'b0;
        end else if (w_mc_hold) begin
          w_en              = 5'b11000;
          w_vld_nxt[STG_WB] = r_vld[STG_MA];
          w_vld_nxt[STG_MA] = 1'b0;
          if (r_state == RUN) begin
            w_state_nxt  = MCWAIT;
            w_mc_cnt_nxt = c_MC_LOAD;
          end else begin
            w_mc_cnt_nxt = r_mc_cnt - c_MC_W'(1);
          end
        end else begin
          if (r_state == MCWAIT)
            w_state_nxt = RUN;
          w_branch          = r_vld[STG_EX] && bus.ex_br_taken;
          w_lu_stall        = w_lu_hit && !w_branch;
          w_vld_nxt[STG_WB] = r_vld[STG_MA];
          w_vld_nxt[STG_MA] = r_vld[STG_EX];
          if (w_lu_stall) begin
            w_en              = 5'b11100;
            w_vld_nxt[STG_EX] = 1'b0;
          end else begin
            w_en              = 5'b11111;
            w_vld_nxt[STG_EX] = r_vld[STG_DI];
            w_vld_nxt[STG_DI] = r_vld[STG_FI];
          end

          w_fi_rdy = (r_state == RUN) && w_en[STG_FI] && !w_branch;
          w_fetch  = w_fi_rdy && bus.fi_vld;

          if (w_branch) begin
            w_pc_nxt          = bus.ex_br_tgt;
            w_vld_nxt[STG_FI] = 1'b0;
            w_vld_nxt[STG_DI] = 1'b0;
          end else if (w_en[STG_FI]) begin
            w_vld_nxt[STG_FI] = w_fetch;
            if (w_fetch)
              w_pc_nxt = r_pc + XLEN'(4);
          end
        end
      end

      default: w_state_nxt = BOOT;
    endcase

    if (!rstn) begin
      w_en     = '0;
      w_fi_rdy = 1'b0;
    end
  end

  assign bus.fi_rdy    = w_fi_rdy;
  assign bus.fi_addr   = r_pc;
  assign bus.stg_en    = w_en;
  assign bus.stg_vld   = r_vld;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
